// File: rtl/port_ff_latch.sv
// port_ff_latch: glitch-filtered Z80 OUT-port latch with write counter; readback path built only with PORTFF_READBACK_EN.
module port_ff_latch #(
  parameter logic [7:0] PORT_ADDR  = 8'hFF,
  parameter int         FILTER_CYC = 2
) (
  input  logic       pll0_100MHz,
  input  logic       reset,
  input  logic [7:0] cpuA,
  input  logic [7:0] cpuDO,
  input  logic       cpu_iorq_n,
  input  logic       cpu_wr_n,
  input  logic       cpu_rd_n,
  input  logic       cpu_m1_n,
  output logic [7:0] portFFDO,
  output logic       portFF_stb,
  output logic [7:0] wr_count,
  output logic       portFF_rd_sel,
  output logic [7:0] portFFDI
);
  typedef enum logic [1:0] {IDLE, FILTER, CAPTURE, WAIT_END} state_t;
  localparam logic [2:0] FILT_LAST = 3'(FILTER_CYC);
  state_t state, stateNext;
  logic [2:0] filtCnt, filtCntNext;
  // strobe bits ordered {iorq_n, wr_n, rd_n, m1_n}
  logic [3:0] syncA, syncB;
  logic [7:0] aReg, dReg;
  logic addrHit, wrQual, wrEnd;
  always_ff @(posedge pll0_100MHz or posedge reset)
    if (reset) begin
      syncA <= 4'hF;
      syncB <= 4'hF;
      aReg  <= 8'h00;
      dReg  <= 8'h00;
    end else begin
      syncA <= {cpu_iorq_n, cpu_wr_n, cpu_rd_n, cpu_m1_n};
      syncB <= syncA;
      aReg  <= cpuA;
      dReg  <= cpuDO;
    end
  assign addrHit = aReg == PORT_ADDR;
  assign wrQual  = !syncB[3] && !syncB[2] && syncB[0] && addrHit;
  assign wrEnd   = syncB[3] || syncB[2];
  always_ff @(posedge pll0_100MHz or posedge reset)
    if (reset) begin
      state   <= IDLE;
      filtCnt <= 3'd0;
    end else begin
      state   <= stateNext;
      filtCnt <= filtCntNext;
    end
  always_comb begin
    stateNext   = state;
    filtCntNext = 3'd0;
    case (state)
      IDLE: begin
        filtCntNext = wrQual ? 3'd1 : 3'd0;
        stateNext   = !wrQual ? IDLE : (FILT_LAST == 3'd1 ? CAPTURE : FILTER);
      end
      FILTER: begin
        filtCntNext = wrQual ? filtCnt + 3'd1 : 3'd0;
        stateNext   = !wrQual ? IDLE : (filtCnt + 3'd1 == FILT_LAST ? CAPTURE : FILTER);
      end
      CAPTURE:  stateNext = WAIT_END;
      WAIT_END: stateNext = wrEnd ? IDLE : WAIT_END;
      default:  stateNext = IDLE;
    endcase
  end
  assign portFF_stb = state == CAPTURE;
  always_ff @(posedge pll0_100MHz or posedge reset)
    if (reset) begin
      portFFDO <= 8'h00;
      wr_count <= 8'h00;
    end else if (portFF_stb) begin
      portFFDO <= dReg;
      wr_count <= wr_count + 8'd1;
    end
`ifdef PORTFF_READBACK_EN
  assign portFF_rd_sel = !syncB[3] && !syncB[1] && syncB[0] && addrHit;
  assign portFFDI      = portFFDO;
`else
  logic unusedRd;
  assign unusedRd      = syncB[1];
  assign portFF_rd_sel = 1'b0;
  assign portFFDI      = 8'h00;
`endif
endmodule

// File: tb/tb_port_ff_latch.sv
// tb_port_ff_latch: directed plus randomized Z80 I/O cycles checked against a transaction-level model.
module tb_port_ff_latch;
  localparam int FC = 2;
  logic clk = 0, rst = 1;
  logic [7:0] cpuA = 8'h00, cpuDO = 8'h00;
  logic iorqN = 1, wrN = 1, rdN = 1, m1N = 1;
  logic [7:0] portFFDO, wr_count, portFFDI;
  logic portFF_stb, portFF_rd_sel;
  int nCmp = 0, nErr = 0, stbSeen = 0;
  logic [7:0] expData = 8'h00;
  int expCnt = 0;
  port_ff_latch #(.PORT_ADDR(8'hFF), .FILTER_CYC(FC)) dut (
    .pll0_100MHz(clk), .reset(rst), .cpuA(cpuA), .cpuDO(cpuDO),
    .cpu_iorq_n(iorqN), .cpu_wr_n(wrN), .cpu_rd_n(rdN), .cpu_m1_n(m1N),
    .portFFDO(portFFDO), .portFF_stb(portFF_stb), .wr_count(wr_count),
    .portFF_rd_sel(portFF_rd_sel), .portFFDI(portFFDI)
  );
  always #5 clk = ~clk;
  always @(negedge clk) if (portFF_stb === 1'b1) stbSeen++;
  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    nCmp++;
    assert (obs === exp) else begin
      nErr++;
      $error("FAIL %s: got %02h expected %02h", tag, obs, exp);
    end
  endtask
  // One bus cycle: strobes held low across len rising edges, then idle long enough to settle.
  task automatic doWrite(input logic [7:0] a, input logic [7:0] d, input logic io, input logic m1,
                         input int len, input bit chk);
    int s0;
    s0 = stbSeen;
    @(negedge clk);
    cpuA = a; cpuDO = d; iorqN = io; wrN = 0; m1N = m1;
    repeat (len) @(negedge clk);
    iorqN = 1; wrN = 1; m1N = 1;
    repeat (6) @(negedge clk);
    if (!io && m1 && a == 8'hFF && len >= FC) begin
      expData = d;
      expCnt = (expCnt + 1) % 256;
    end
    if (chk) begin
      check("wr_data", portFFDO, expData);
      check("wr_count", wr_count, 8'(expCnt));
      check("wr_stb", 8'(stbSeen - s0), (!io && m1 && a == 8'hFF && len >= FC) ? 8'd1 : 8'd0);
    end
  endtask
  initial begin
    int s0;
    logic [7:0] a, d;
    bit rbExp;
`ifdef PORTFF_READBACK_EN
    rbExp = 1;
`else
    rbExp = 0;
`endif
    repeat (3) @(negedge clk);
    check("rst_do", portFFDO, 8'h00);
    check("rst_cnt", wr_count, 8'h00);
    check("rst_stb", {7'd0, portFF_stb}, 8'h00);
    check("rst_rdsel", {7'd0, portFF_rd_sel}, 8'h00);
    check("rst_di", portFFDI, 8'h00);
    rst = 0;
    repeat (2) @(negedge clk);
    s0 = stbSeen;
    cpuA = 8'hFF; cpuDO = 8'hA5; iorqN = 0; wrN = 0;
    repeat (3 + FC) @(negedge clk);
    check("lat_do", portFFDO, 8'hA5);
    repeat (30 - 3 - FC) @(negedge clk);
    iorqN = 1; wrN = 1;
    repeat (6) @(negedge clk);
    expData = 8'hA5; expCnt = 1;
    check("long_stb", 8'(stbSeen - s0), 8'd1);
    check("long_cnt", wr_count, 8'd1);
    doWrite(8'hFF, 8'h3C, 0, 1, 1, 1);
    doWrite(8'hFE, 8'h11, 0, 1, 4, 1);
    doWrite(8'hFF, 8'h11, 0, 0, 4, 1);
    doWrite(8'hFF, 8'h11, 1, 1, 4, 1);
    doWrite(8'hFF, 8'h5A, 0, 1, FC, 1);
    @(negedge clk);
    cpuA = 8'hFF; iorqN = 0; rdN = 0;
    repeat (3) @(negedge clk);
    check("rb_sel", {7'd0, portFF_rd_sel}, {7'd0, rbExp});
    check("rb_di", portFFDI, rbExp ? 8'h5A : 8'h00);
    iorqN = 1; rdN = 1;
    repeat (4) @(negedge clk);
    check("rb_idle_sel", {7'd0, portFF_rd_sel}, 8'h00);
    cpuA = 8'hFF; cpuDO = 8'h77; iorqN = 0; wrN = 0;
    repeat (8) @(negedge clk);
    rst = 1;
    repeat (3) @(negedge clk);
    check("mid_rst_do", portFFDO, 8'h00);
    check("mid_rst_cnt", wr_count, 8'h00);
    check("mid_rst_stb", {7'd0, portFF_stb}, 8'h00);
    s0 = stbSeen;
    rst = 0;
    repeat (10) @(negedge clk);
    check("post_rst_do", portFFDO, 8'h77);
    check("post_rst_cnt", wr_count, 8'd1);
    iorqN = 1; wrN = 1;
    repeat (6) @(negedge clk);
    check("post_rst_stb", 8'(stbSeen - s0), 8'd1);
    expData = 8'h77; expCnt = 1;
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 3))
        0, 1: a = 8'hFF;
        2: a = 8'hFE;
        default: a = 8'($urandom);
      endcase
      d = 8'($urandom);
      doWrite(a, d, $urandom_range(0, 4) == 0, $urandom_range(0, 4) != 0, $urandom_range(1, 5), 1);
    end
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    expData = 8'h00; expCnt = 0;
    for (int i = 0; i < 257; i++) doWrite(8'hFF, 8'($urandom), 0, 1, 3, 0);
    check("wrap_cnt", wr_count, 8'h01);
    check("wrap_do", portFFDO, expData);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
    $finish;
  end
endmodule
